// File: rtl/mcc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, ALUOp codes, Op/Funct values.
package mcc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/mcc_alu_decoder.sv
// Combinational ALUOp selection from state, Op and Funct, plus shift and Funct-legality flags.
module mcc_alu_decoder
    import mcc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       shift_sel,
    output logic       funct_valid
);

    logic [3:0] funct_alu;
    logic [3:0] op_alu;

    always_comb begin
        funct_alu   = ALU_ADD;
        funct_valid = 1'b1;
        shift_sel   = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: funct_alu = ALU_ADD;
            FN_SUB, FN_SUBU: funct_alu = ALU_SUB;
            FN_AND:          funct_alu = ALU_AND;
            FN_OR:           funct_alu = ALU_OR;
            FN_XOR:          funct_alu = ALU_XOR;
            FN_NOR:          funct_alu = ALU_NOR;
            FN_SLT:          funct_alu = ALU_SLT;
            FN_SLL: begin funct_alu = ALU_SLL; shift_sel = 1'b1; end
            FN_SRL: begin funct_alu = ALU_SRL; shift_sel = 1'b1; end
            FN_SRA: begin funct_alu = ALU_SRA; shift_sel = 1'b1; end
            default:         funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        op_alu = ALU_ADD;
        case (op)
            OP_ANDI: op_alu = ALU_AND;
            OP_ORI:  op_alu = ALU_OR;
            OP_XORI: op_alu = ALU_XOR;
            OP_SLTI: op_alu = ALU_SLT;
            OP_LUI:  op_alu = ALU_LUI;
            default: op_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        case (state)
            S_EXECR:  alu_op = funct_alu;
            S_EXECI:  alu_op = op_alu;
            S_BRANCH: alu_op = ALU_SUB;
            default:  alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcc_control.sv
// Multicycle MIPS control FSM: registered state, combinational control decode.
// Optional build macro MCC_BNE_EN enables bne (Op 0x05); otherwise it decodes as illegal.
module mcc_control
    import mcc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ExtZero,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUOp,
    output logic       Illegal
);

    state_t state;
    state_t state_next;
    logic   shift_sel;
    logic   funct_valid;
    logic   bne_en;
    logic   dec_illegal;

`ifdef MCC_BNE_EN
    assign bne_en = 1'b1;
`else
    assign bne_en = 1'b0;
`endif

    mcc_alu_decoder u_alu_decoder (
        .state       (state),
        .op          (Op),
        .funct       (Funct),
        .alu_op      (ALUOp),
        .shift_sel   (shift_sel),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = S_FETCH;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        state_next  = funct_valid ? S_EXECR : S_FETCH;
                        dec_illegal = ~funct_valid;
                    end
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI:
                        state_next = S_EXECI;
                    OP_BEQ: state_next = S_BRANCH;
                    OP_BNE: begin
                        state_next  = bne_en ? S_BRANCH : S_FETCH;
                        dec_illegal = ~bne_en;
                    end
                    OP_J:   state_next = S_JUMP;
                    default: dec_illegal = 1'b1;
                endcase
            end
            S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ExtZero  = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        Illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCEn    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = dec_illegal;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: ALUSrcA = shift_sel ? 2'b10 : 2'b01;
            S_EXECI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ExtZero = (Op == OP_ANDI) || (Op == OP_ORI) || (Op == OP_XORI);
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (Op == OP_RTYPE);
            end
            S_BRANCH: begin
                ALUSrcA = 2'b01;
                PCSrc   = 2'b01;
                // Zero feeds PCEn combinationally so the branch resolves in this same cycle
                PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        // Writes are suppressed during reset; selects keep their FETCH values
        if (rst) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule
